instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Reverse of the instruction decode path: accepts symbolic instructions (op index plus fields) over a valid/ready handshake and packs each into a 32-bit MIPS word.
- Buffers encoded words in a 2-entry FIFO and writes them sequentially into instruction memory from BASE_ADDR.
- Used for in-system program loading and for self-checking benches that feed the decoder.

Parameters:
- BASE_ADDR, 32'h0000_3000, byte address of the first word written.
- IM_WORDS, 4096, IM depth in words (power of two); the write index wraps modulo this.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; IDLE->RUN, write index cleared to 0.
- in_valid  in  1  source has an instruction.
- in_ready  out  1  encoder accepts this cycle.
- in_last  in  1  marks the final instruction of the program.
- in_op  in  6  op index: add0 addi1 addiu2 addu3 and4 andi5 beq6 bgez7 bgtz8 blez9 bltz10 bne11 div12 divu13 j14 jal15 jalr16 jr17 lb18 lbu19 lh20 lhu21 lui22 lw23 mfhi24 mflo25 mthi26 mtlo27 mult28 multu29 nor30 or31 ori32 sb33 sh34 sll35 sllv36 slt37 slti38 sltiu39 sltu40 sra41 srav42 srl43 srlv44 sub45 subu46 sw47 xor48 xori49 eret50 mfc051 mtc052.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields.
- in_imm  in  26  imm16 in [15:0] for I-type; target in [25:0] for j/jal.
- im_we  out  1  IM write strobe.
- im_ready  in  1  IM accepts the write this cycle.
- im_addr  out  32  byte address of the write.
- im_wdata  out  32  encoded word.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at the end of a program.
- err  out  1  sticky illegal-op flag.
- err_addr  out  32  im_addr of the first illegal op.
- word_cnt  out  16  words written since start.

Behaviour:
- Clock and reset: clk, single clock domain. Reset is synchronous and active-high on port reset. Reset clears state to IDLE, empties the FIFO and zeroes every output (in_ready, im_we, im_addr, im_wdata, busy, done, err, err_addr, word_cnt). Reset mid-program abandons it with no further writes.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: in_ready=0. start -> RUN.
  - RUN: in_ready = FIFO not full. A handshake (in_valid & in_ready) pushes the encoded word. A handshake with in_last -> DRAIN.
  - DRAIN: in_ready=0. FIFO empty and no write pending -> DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - start outside IDLE is ignored.
- Encoding is combinational from the input fields; the word enters the FIFO on the handshake edge. Latency from handshake to im_we is 1 cycle when the FIFO is empty.
- Encoding rules (unused fields forced to 0):
  - R-ALU (add addu sub subu and or nor xor slt sltu sllv srlv srav): {0, rs, rt, rd, 0, func}.
  - Shifts sll/srl/sra: rs=0, shamt=in_shamt.
  - mult/multu/div/divu: rd=0, shamt=0.
  - mfhi/mflo: rd only. mthi/mtlo/jr: rs only. jalr: rs, rd.
  - I-type: {op, rs, rt, imm16}; lui forces rs=0; bgtz/blez force rt=0; bgez: opcode 6'b000001, rt=1; bltz: opcode 6'b000001, rt=0.
  - j/jal: {op, target26}.
  - eret: 32'h4200_0018. mfc0: {6'b010000, 5'b00000, rt, rd, 11'b0}. mtc0: {6'b010000, 5'b00100, rt, rd, 11'b0}.
- Illegal op (53..63): the word is encoded as 32'h0000_0000 (nop) and still written. The first occurrence sets err and captures err_addr. err and err_addr are cleared only by reset or start.
- Write port: im_we = FIFO not empty; im_wdata = FIFO head; im_addr = BASE_ADDR + ((idx mod IM_WORDS) << 2). On im_we & im_ready: pop, idx+1, word_cnt+1 (saturates at 16'hFFFF). im_we stays asserted with stable addr/data while im_ready=0.
- FIFO full and im_ready=0: in_ready=0, no input is lost. Simultaneous push and pop while full is not allowed, since in_ready is computed from the registered full flag.
- Address wrap: idx IM_WORDS-1 -> 0 overwrites from BASE_ADDR. No flag is raised.

Optional Feature:
- Macro ENC_CP0_EN.
  - Defined: ops 50-52 encode as above.
  - Undefined: ops 50-52 are treated as illegal (nop plus err).

Test Plan:
- Reset, start, then addu rs=1 rt=2 rd=3 with in_last, im_ready=1 -> one cycle later im_we=1, im_addr=32'h3000, im_wdata=32'h0022_1821; then done pulses, word_cnt=1.
- ori rs=0 rt=1 imm=16'h1234, then lui rt=2 imm=16'hFFFF (in_rs=7) -> 32'h3401_1234 @3000, 32'h3C02_FFFF @3004 (rs forced 0).
- bgez rs=4 imm=16'hFFFE, bltz rs=4 same imm -> 32'h0481_FFFE, 32'h0480_FFFE.
- im_ready held 0 for 5 cycles while 4 instructions are offered -> in_ready drops after 2 accepted, im_addr/wdata stable; release -> all 4 written in order with no loss.
- op=60 third in the stream -> word 32'h0000_0000 at 32'h3008, err=1, err_addr=32'h3008; a later start clears err.
- With ENC_CP0_EN: mtc0 rt=5 rd=12 -> 32'h4085_6000, eret -> 32'h4200_0018. Without the macro: both ops write 0 and set err.

Source files
------------

// File: rtl/instr_encoder.sv
// Symbolic-instruction to MIPS word encoder feeding instruction memory through a 2-entry FIFO.
// Optional CP0 ops (eret/mfc0/mtc0) are encoded only when ENC_CP0_EN is defined.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          IM_WORDS  = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [5:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [25:0] in_imm,
  output logic        im_we,
  input  logic        im_ready,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] err_addr,
  output logic [15:0] word_cnt
);

  localparam int IDX_W = (IM_WORDS > 1) ? $clog2(IM_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [31:0]       fifo_mem [2];
  logic              wr_ptr_reg, rd_ptr_reg;
  logic [1:0]        count_reg;
  logic [IDX_W-1:0]  idx_reg, push_idx_reg;
  logic [15:0]       word_cnt_reg;
  logic              err_reg;
  logic [31:0]       err_addr_reg;
  logic [31:0]       enc_word;
  logic              enc_illegal;
  logic              push, pop;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Encoder: unused fields are zeroed so the word is canonical.
  always_comb begin
    enc_word    = 32'h0000_0000;
    enc_illegal = 1'b0;
    case (in_op)
      6'd0:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h20);
      6'd1:  enc_word = i_word(6'h08, in_rs, in_rt, in_imm[15:0]);
      6'd2:  enc_word = i_word(6'h09, in_rs, in_rt, in_imm[15:0]);
      6'd3:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h21);
      6'd4:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h24);
      6'd5:  enc_word = i_word(6'h0C, in_rs, in_rt, in_imm[15:0]);
      6'd6:  enc_word = i_word(6'h04, in_rs, in_rt, in_imm[15:0]);
      6'd7:  enc_word = i_word(6'h01, in_rs, 5'd1, in_imm[15:0]);
      6'd8:  enc_word = i_word(6'h07, in_rs, 5'd0, in_imm[15:0]);
      6'd9:  enc_word = i_word(6'h06, in_rs, 5'd0, in_imm[15:0]);
      6'd10: enc_word = i_word(6'h01, in_rs, 5'd0, in_imm[15:0]);
      6'd11: enc_word = i_word(6'h05, in_rs, in_rt, in_imm[15:0]);
      6'd12: enc_word = r_word(in_rs, in_rt, 5'd0, 5'd0, 6'h1A);
      6'd13: enc_word = r_word(in_rs, in_rt, 5'd0, 5'd0, 6'h1B);
      6'd14: enc_word = {6'h02, in_imm};
      6'd15: enc_word = {6'h03, in_imm};
      6'd16: enc_word = r_word(in_rs, 5'd0, in_rd, 5'd0, 6'h09);
      6'd17: enc_word = r_word(in_rs, 5'd0, 5'd0, 5'd0, 6'h08);
      6'd18: enc_word = i_word(6'h20, in_rs, in_rt, in_imm[15:0]);
      6'd19: enc_word = i_word(6'h24, in_rs, in_rt, in_imm[15:0]);
      6'd20: enc_word = i_word(6'h21, in_rs, in_rt, in_imm[15:0]);
      6'd21: enc_word = i_word(6'h25, in_rs, in_rt, in_imm[15:0]);
      6'd22: enc_word = i_word(6'h0F, 5'd0, in_rt, in_imm[15:0]);
      6'd23: enc_word = i_word(6'h23, in_rs, in_rt, in_imm[15:0]);
      6'd24: enc_word = r_word(5'd0, 5'd0, in_rd, 5'd0, 6'h10);
      6'd25: enc_word = r_word(5'd0, 5'd0, in_rd, 5'd0, 6'h12);
      6'd26: enc_word = r_word(in_rs, 5'd0, 5'd0, 5'd0, 6'h11);
      6'd27: enc_word = r_word(in_rs, 5'd0, 5'd0, 5'd0, 6'h13);
      6'd28: enc_word = r_word(in_rs, in_rt, 5'd0, 5'd0, 6'h18);
      6'd29: enc_word = r_word(in_rs, in_rt, 5'd0, 5'd0, 6'h19);
      6'd30: enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h27);
      6'd31: enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h25);
      6'd32: enc_word = i_word(6'h0D, in_rs, in_rt, in_imm[15:0]);
      6'd33: enc_word = i_word(6'h28, in_rs, in_rt, in_imm[15:0]);
      6'd34: enc_word = i_word(6'h29, in_rs, in_rt, in_imm[15:0]);
      6'd35: enc_word = r_word(5'd0, in_rt, in_rd, in_shamt, 6'h00);
      6'd36: enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h04);
      6'd37: enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h2A);
      6'd38: enc_word = i_word(6'h0A, in_rs, in_rt, in_imm[15:0]);
      6'd39: enc_word = i_word(6'h0B, in_rs, in_rt, in_imm[15:0]);
      6'd40: enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h2B);
      6'd41: enc_word = r_word(5'd0, in_rt, in_rd, in_shamt, 6'h03);
      6'd42: enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h07);
      6'd43: enc_word = r_word(5'd0, in_rt, in_rd, in_shamt, 6'h02);
      6'd44: enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h06);
      6'd45: enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h22);
      6'd46: enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h23);
      6'd47: enc_word = i_word(6'h2B, in_rs, in_rt, in_imm[15:0]);
      6'd48: enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h26);
      6'd49: enc_word = i_word(6'h0E, in_rs, in_rt, in_imm[15:0]);
`ifdef ENC_CP0_EN
      6'd50: enc_word = 32'h4200_0018;
      6'd51: enc_word = {6'b010000, 5'b00000, in_rt, in_rd, 11'b0};
      6'd52: enc_word = {6'b010000, 5'b00100, in_rt, in_rd, 11'b0};
`endif
      default: enc_illegal = 1'b1;
    endcase
  end

  assign push = in_valid & in_ready;
  assign pop  = im_we & im_ready;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start) state_next = RUN;
      RUN:   if (push && in_last) state_next = DRAIN;
      DRAIN: if (count_reg == 2'd0) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // in_ready comes from the registered count, so a full FIFO never sees push and pop together.
  always_comb begin
    in_ready = (state_reg == RUN) && (count_reg != 2'd2);
    busy     = (state_reg != IDLE);
    done     = (state_reg == DONE);
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= enc_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      count_reg    <= 2'd0;
      idx_reg      <= '0;
      push_idx_reg <= '0;
      word_cnt_reg <= 16'd0;
      err_reg      <= 1'b0;
      err_addr_reg <= 32'h0;
    end else if (start && state_reg == IDLE) begin
      idx_reg      <= '0;
      push_idx_reg <= '0;
      word_cnt_reg <= 16'd0;
      err_reg      <= 1'b0;
      err_addr_reg <= 32'h0;
    end else begin
      count_reg <= count_reg + 2'(push) - 2'(pop);
      if (push) begin
        wr_ptr_reg   <= ~wr_ptr_reg;
        push_idx_reg <= push_idx_reg + IDX_W'(1);
        // The pushed word lands at push_idx since writes drain strictly in order.
        if (enc_illegal && !err_reg) begin
          err_reg      <= 1'b1;
          err_addr_reg <= BASE_ADDR + (32'(push_idx_reg) << 2);
        end
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
        idx_reg    <= idx_reg + IDX_W'(1);
        if (word_cnt_reg != 16'hFFFF) word_cnt_reg <= word_cnt_reg + 16'd1;
      end
    end
  end

  assign im_we    = (count_reg != 2'd0);
  assign im_wdata = im_we ? fifo_mem[rd_ptr_reg] : 32'h0;
  assign im_addr  = im_we ? BASE_ADDR + (32'(idx_reg) << 2) : 32'h0;
  assign err      = err_reg;
  assign err_addr = err_addr_reg;
  assign word_cnt = word_cnt_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed programs plus randomized ones against a table-driven model.
module tb_instr_encoder;
  localparam logic [31:0] BASE = 32'h0000_3000;
  localparam int IMW = 16;
  localparam int F_RS = 1, F_RT = 2, F_RD = 4, F_SH = 8, F_IMM = 16, F_T26 = 32;
  localparam int R3 = F_RS | F_RT | F_RD;
  localparam int IT = F_RS | F_RT | F_IMM;

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, in_valid = 1'b0, in_last = 1'b0, im_ready = 1'b1;
  logic [5:0] in_op = '0;
  logic [4:0] in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [25:0] in_imm = '0;
  logic in_ready, im_we, busy, done, err;
  logic [31:0] im_addr, im_wdata, err_addr;
  logic [15:0] word_cnt;

  int checks = 0, errors = 0;

  instr_encoder #(.BASE_ADDR(BASE), .IM_WORDS(IMW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_imm(in_imm), .im_we(im_we), .im_ready(im_ready),
    .im_addr(im_addr), .im_wdata(im_wdata), .busy(busy), .done(done), .err(err),
    .err_addr(err_addr), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  // Reference tables: opcode, function, which input fields are used, fixed rs/rt values.
  int opc_t[64], fn_t[64], mask_t[64], rsfix_t[64], rtfix_t[64];
  bit legal_t[64];

  logic [31:0] exp_q[$];
  int m_push, m_wr;
  logic m_err;
  logic [31:0] m_err_addr;
  bit rand_rdy = 1'b0;

  task automatic def(input int op, input int opc, input int fn, input int mask,
                     input int rsfix = 0, input int rtfix = 0);
    opc_t[op] = opc; fn_t[op] = fn; mask_t[op] = mask;
    rsfix_t[op] = rsfix; rtfix_t[op] = rtfix; legal_t[op] = 1'b1;
  endtask

  task automatic init_tables();
    def(0,0,'h20,R3);  def(1,'h08,0,IT); def(2,'h09,0,IT); def(3,0,'h21,R3);
    def(4,0,'h24,R3);  def(5,'h0C,0,IT); def(6,'h04,0,IT); def(7,'h01,0,F_RS|F_IMM,0,1);
    def(8,'h07,0,F_RS|F_IMM); def(9,'h06,0,F_RS|F_IMM); def(10,'h01,0,F_RS|F_IMM);
    def(11,'h05,0,IT); def(12,0,'h1A,F_RS|F_RT); def(13,0,'h1B,F_RS|F_RT);
    def(14,'h02,0,F_T26); def(15,'h03,0,F_T26); def(16,0,'h09,F_RS|F_RD); def(17,0,'h08,F_RS);
    def(18,'h20,0,IT); def(19,'h24,0,IT); def(20,'h21,0,IT); def(21,'h25,0,IT);
    def(22,'h0F,0,F_RT|F_IMM); def(23,'h23,0,IT); def(24,0,'h10,F_RD); def(25,0,'h12,F_RD);
    def(26,0,'h11,F_RS); def(27,0,'h13,F_RS); def(28,0,'h18,F_RS|F_RT); def(29,0,'h19,F_RS|F_RT);
    def(30,0,'h27,R3); def(31,0,'h25,R3); def(32,'h0D,0,IT); def(33,'h28,0,IT); def(34,'h29,0,IT);
    def(35,0,'h00,F_RT|F_RD|F_SH); def(36,0,'h04,R3); def(37,0,'h2A,R3); def(38,'h0A,0,IT);
    def(39,'h0B,0,IT); def(40,0,'h2B,R3); def(41,0,'h03,F_RT|F_RD|F_SH); def(42,0,'h07,R3);
    def(43,0,'h02,F_RT|F_RD|F_SH); def(44,0,'h06,R3); def(45,0,'h22,R3); def(46,0,'h23,R3);
    def(47,'h2B,0,IT); def(48,0,'h26,R3); def(49,'h0E,0,IT);
`ifdef ENC_CP0_EN
    def(50,'h10,'h18,0,16,0); def(51,'h10,0,F_RT|F_RD,0,0); def(52,'h10,0,F_RT|F_RD,4,0);
`endif
  endtask

  function automatic logic [31:0] model(input int op, input int rs, input int rt, input int rd,
                                        input int sh, input int imm);
    longint w;
    int m, f_rs, f_rt, f_rd, f_sh, f_imm;
    if (!legal_t[op]) return 32'h0;
    m = mask_t[op];
    if ((m & F_T26) != 0) begin
      w = longint'(opc_t[op]) * 67108864 + longint'(imm % 67108864);
      return w[31:0];
    end
    f_rs  = ((m & F_RS)  != 0) ? rs : rsfix_t[op];
    f_rt  = ((m & F_RT)  != 0) ? rt : rtfix_t[op];
    f_rd  = ((m & F_RD)  != 0) ? rd : 0;
    f_sh  = ((m & F_SH)  != 0) ? sh : 0;
    f_imm = ((m & F_IMM) != 0) ? imm % 65536 : 0;
    w = longint'(opc_t[op]) * 67108864 + longint'(f_rs) * 2097152 + longint'(f_rt) * 65536
      + longint'(f_rd) * 2048 + longint'(f_sh) * 64 + longint'(fn_t[op]) + longint'(f_imm);
    return w[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Write monitor: every accepted IM write must match the next expected word and address.
  always @(negedge clk) begin
    if (im_we === 1'b1 && im_ready === 1'b1) begin
      chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        chk("wr_addr", im_addr, BASE + 32'((m_wr % IMW) * 4));
        chk("wr_data", im_wdata, exp_q.pop_front());
        $display("write #%0d addr=%h data=%h", m_wr, im_addr, im_wdata);
        m_wr++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) im_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic drive(input int op, input int rs, input int rt, input int rd, input int sh,
                       input int imm, input bit last);
    in_op = 6'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_shamt = 5'(sh); in_imm = 26'(imm); in_last = last; in_valid = 1'b1;
  endtask

  task automatic send_exp(input int op, input int rs, input int rt, input int rd, input int sh,
                          input int imm, input bit last, input logic [31:0] exp);
    bit acc = 1'b0;
    int c = 0;
    drive(op, rs, rt, rd, sh, imm, last);
    while (!acc && c < 200) begin
      @(negedge clk);
      c++;
      if (in_ready) begin
        exp_q.push_back(exp);
        if (!legal_t[op] && !m_err) begin
          m_err = 1'b1;
          m_err_addr = BASE + 32'((m_push % IMW) * 4);
        end
        m_push++;
        @(posedge clk); #1;
        acc = 1'b1;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic send(input int op, input int rs, input int rt, input int rd, input int sh,
                      input int imm, input bit last);
    send_exp(op, rs, rt, rd, sh, imm, last, model(op, rs, rt, rd, sh, imm));
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    exp_q.delete();
    m_push = 0; m_wr = 0; m_err = 1'b0; m_err_addr = 32'h0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    int c = 0;
    while (!seen && c < 500) begin
      @(negedge clk);
      c++;
      if (done) seen = 1'b1;
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    chk({name, "_word_cnt"}, 32'(word_cnt), 32'(m_wr));
    chk({name, "_all_written"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_err"}, 32'(err), 32'(m_err));
    chk({name, "_err_addr"}, err_addr, m_err_addr);
    $display("program %s: words=%0d err=%0b err_addr=%h", name, word_cnt, err, err_addr);
    @(negedge clk);
    chk({name, "_done_one_cycle"}, 32'(done), 32'd0);
    chk({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] a0, d0;
    int len;
    init_tables();
    m_push = 0; m_wr = 0; m_err = 1'b0; m_err_addr = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 0); chk("rst_im_we", 32'(im_we), 0);
    chk("rst_im_addr", im_addr, 0);        chk("rst_im_wdata", im_wdata, 0);
    chk("rst_busy", 32'(busy), 0);         chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);           chk("rst_err_addr", err_addr, 0);
    chk("rst_word_cnt", 32'(word_cnt), 0);
    reset = 1'b0;

    // Single addu with first-write latency
    do_start();
    chk("start_busy", 32'(busy), 1);
    chk("start_in_ready", 32'(in_ready), 1);
    send_exp(3, 1, 2, 3, 0, 0, 1'b1, 32'h0022_1821);
    chk("lat_im_we", 32'(im_we), 1);
    chk("lat_im_addr", im_addr, 32'h3000);
    chk("lat_im_wdata", im_wdata, 32'h0022_1821);
    wait_done("addu");
    chk("addu_word_cnt_1", 32'(word_cnt), 1);

    // I-type field forcing and REGIMM branches
    do_start();
    send_exp(32, 0, 1, 31, 31, 'h3FF_1234, 1'b0, 32'h3401_1234);
    send_exp(22, 7, 2, 31, 31, 'h000_FFFF, 1'b0, 32'h3C02_FFFF);
    send_exp(7, 4, 9, 0, 0, 'h000_FFFE, 1'b0, 32'h0481_FFFE);
    send_exp(10, 4, 9, 0, 0, 'h000_FFFE, 1'b1, 32'h0480_FFFE);
    wait_done("itype");

    // Backpressure: FIFO fills after two, head held stable
    im_ready = 1'b0;
    do_start();
    send(0, 5, 6, 7, 0, 0, 1'b0);
    send(2, 8, 9, 0, 0, 'h8001, 1'b0);
    drive(31, 10, 11, 12, 0, 0, 1'b0);
    @(negedge clk);
    a0 = im_addr; d0 = im_wdata;
    chk("stall_addr", a0, BASE);
    chk("stall_data", d0, model(0, 5, 6, 7, 0, 0));
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_im_we", 32'(im_we), 1);
      chk("stall_addr_stable", im_addr, a0);
      chk("stall_data_stable", im_wdata, d0);
      @(negedge clk);
    end
    @(posedge clk); #1 im_ready = 1'b1;
    send(31, 10, 11, 12, 0, 0, 1'b0);
    send(35, 0, 13, 14, 9, 0, 1'b1);
    wait_done("stall");
    chk("stall_word_cnt_4", 32'(word_cnt), 4);

    // Illegal ops: first sets err_addr, later ones do not move it
    do_start();
    send(3, 1, 1, 1, 0, 0, 1'b0);
    send(1, 2, 3, 0, 0, 'h7FFF, 1'b0);
    send_exp(60, 1, 2, 3, 4, 'h1234, 1'b0, 32'h0);
    send_exp(63, 1, 2, 3, 4, 'h1234, 1'b1, 32'h0);
    wait_done("illegal");
    chk("illegal_err", 32'(err), 1);
    chk("illegal_err_addr", err_addr, 32'h3008);
    do_start();
    chk("start_clears_err", 32'(err), 0);
    chk("start_clears_err_addr", err_addr, 0);

    // CP0 ops: encoded when enabled, nop plus err otherwise
    im_ready = 1'b1;
`ifdef ENC_CP0_EN
    send_exp(52, 3, 5, 12, 7, 'h55, 1'b0, 32'h4085_6000);
    send_exp(50, 3, 5, 12, 7, 'h55, 1'b1, 32'h4200_0018);
    wait_done("cp0");
    chk("cp0_err", 32'(err), 0);
`else
    send_exp(52, 3, 5, 12, 7, 'h55, 1'b0, 32'h0);
    send_exp(50, 3, 5, 12, 7, 'h55, 1'b1, 32'h0);
    wait_done("cp0");
    chk("cp0_err", 32'(err), 1);
    chk("cp0_err_addr", err_addr, BASE);
`endif

    // Reset mid-program abandons queued writes
    im_ready = 1'b0;
    do_start();
    send(0, 1, 2, 3, 0, 0, 1'b0);
    send(3, 4, 5, 6, 0, 0, 1'b0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_im_we", 32'(im_we), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_word_cnt", 32'(word_cnt), 0);
    chk("midrst_in_ready", 32'(in_ready), 0);
    reset = 1'b0;
    exp_q.delete();
    im_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_write", 32'(im_we), 0);

    // Randomized programs with random IM backpressure; the 20-word one wraps the index
    rand_rdy = 1'b1;
    for (int p = 0; p < 3; p++) begin
      len = (p == 1) ? 20 : int'($urandom_range(3, 9));
      do_start();
      for (int k = 0; k < len; k++)
        send(int'($urandom_range(0, 63)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 26'h3FF_FFFF)), (k == len - 1));
      wait_done($sformatf("rand%0d", p));
      chk("rand_word_cnt", 32'(word_cnt), 32'(len));
    end
    rand_rdy = 1'b0;
    im_ready = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
